// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    MDBUSY = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MULDIV_LAT_DEF = 4;
  localparam int         CNT_W_DEF      = 4;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side view of the hazard controller: ID/EX hazard inputs and freeze/flush outputs.
// Optional stall counters are present when STALL_PERF_EN is defined.
interface hazard_stall_controller_if;

  logic [4:0]  Rs_IF_ID;
  logic [4:0]  Rt_IF_ID;
  logic        Uses_Rt_IF_ID;
  logic [4:0]  Rt_ID_EX;
  logic        Mem_Read_ID_EX;
  logic        Branch_Taken_ID;
  logic        Jump_ID;
  logic        MulDiv_Start_ID_EX;

  logic        PC_Write;
  logic        IF_ID_Write;
  logic        ID_EX_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Bubble;
  logic        EX_MEM_Bubble;
  logic        MulDiv_Busy;
  logic        MulDiv_Done;

`ifdef STALL_PERF_EN
  logic        Perf_Clr;
  logic [15:0] Ld_Stall_Cnt;
  logic [15:0] Md_Stall_Cnt;
  logic [15:0] Flush_Cnt;
`endif

  // Level signals only, no handshake: the datapath samples the enables every
  // rising clk edge, and the controller's outputs are valid for that edge.
  modport master (
`ifdef STALL_PERF_EN
    output Perf_Clr,
    input  Ld_Stall_Cnt, Md_Stall_Cnt, Flush_Cnt,
`endif
    output Rs_IF_ID, Rt_IF_ID, Uses_Rt_IF_ID, Rt_ID_EX, Mem_Read_ID_EX,
    output Branch_Taken_ID, Jump_ID, MulDiv_Start_ID_EX,
    input  PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush,
    input  ID_EX_Bubble, EX_MEM_Bubble, MulDiv_Busy, MulDiv_Done
  );

  modport slave (
`ifdef STALL_PERF_EN
    input  Perf_Clr,
    output Ld_Stall_Cnt, Md_Stall_Cnt, Flush_Cnt,
`endif
    input  Rs_IF_ID, Rt_IF_ID, Uses_Rt_IF_ID, Rt_ID_EX, Mem_Read_ID_EX,
    input  Branch_Taken_ID, Jump_ID, MulDiv_Start_ID_EX,
    output PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush,
    output ID_EX_Bubble, EX_MEM_Bubble, MulDiv_Busy, MulDiv_Done
  );

endinterface

// File: rtl/muldiv_timer.sv
// Loadable down-counter tracking the remaining EX cycles of a mul/div op.
module muldiv_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             is_last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_last = (cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_controller.sv
// Freeze/flush sequencing for the 5-stage core: mul/div freeze > load-use stall > branch flush.
// Define STALL_PERF_EN to add saturating stall/flush event counters.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  hazard_stall_controller_if.slave  hz,
  output hz_state_t                 state_dbg
);

  if (MULDIV_LAT < 2 || MULDIV_LAT > 15 || (1 << CNT_W) <= MULDIV_LAT) begin : g_bad_cfg
    $error("hazard_stall_controller: illegal MULDIV_LAT/CNT_W combination");
  end

  hz_state_t state, next_state;
  logic      load_use, redirect, md_is_last;
  logic      md_load, md_dec;
  logic      pc_write, if_id_write, id_ex_write, if_id_flush;
  logic      id_ex_bubble, ex_mem_bubble, md_busy, md_done;

  assign load_use = hz.Mem_Read_ID_EX && (hz.Rt_ID_EX != REG_ZERO) &&
                    ((hz.Rt_ID_EX == hz.Rs_IF_ID) ||
                     (hz.Uses_Rt_IF_ID && (hz.Rt_ID_EX == hz.Rt_IF_ID)));
  assign redirect = hz.Branch_Taken_ID || hz.Jump_ID;

  always_comb begin
    next_state    = state;
    md_load       = 1'b0;
    md_dec        = 1'b0;
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    id_ex_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    md_busy       = 1'b0;
    md_done       = 1'b0;
    if (rst) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      id_ex_write = 1'b1;
      case (state)
        RUN: begin
          if (hz.MulDiv_Start_ID_EX) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            md_load       = 1'b1;
            next_state    = MDBUSY;
          end else if (load_use) begin
            // Hold PC and IF/ID; ID/EX still loads, but with a zeroed bubble.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else begin
            if_id_flush = redirect;
          end
        end
        MDBUSY: begin
          md_busy = 1'b1;
          md_dec  = 1'b1;
          if (md_is_last) begin
            md_done     = 1'b1;
            if_id_flush = redirect;
            next_state  = RUN;
          end else begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  muldiv_timer #(.CNT_W(CNT_W)) u_muldiv_timer (
    .clk     (clk),
    .rst_n   (rst),
    .load    (md_load),
    .value   (CNT_W'(MULDIV_LAT - 1)),
    .dec     (md_dec),
    .is_last (md_is_last)
  );

  assign hz.PC_Write      = pc_write;
  assign hz.IF_ID_Write   = if_id_write;
  assign hz.ID_EX_Write   = id_ex_write;
  assign hz.IF_ID_Flush   = if_id_flush;
  assign hz.ID_EX_Bubble  = id_ex_bubble;
  assign hz.EX_MEM_Bubble = ex_mem_bubble;
  assign hz.MulDiv_Busy   = md_busy;
  assign hz.MulDiv_Done   = md_done;
  assign state_dbg        = state;

`ifdef STALL_PERF_EN
  logic [15:0] ld_cnt, md_cnt, fl_cnt;

  // Clear beats increment; each counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_cnt <= '0;
      md_cnt <= '0;
      fl_cnt <= '0;
    end else if (hz.Perf_Clr) begin
      ld_cnt <= '0;
      md_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      if (id_ex_bubble  && (ld_cnt != 16'hFFFF)) ld_cnt <= ld_cnt + 16'd1;
      if (ex_mem_bubble && (md_cnt != 16'hFFFF)) md_cnt <= md_cnt + 16'd1;
      if (if_id_flush   && (fl_cnt != 16'hFFFF)) fl_cnt <= fl_cnt + 16'd1;
    end
  end

  assign hz.Ld_Stall_Cnt = ld_cnt;
  assign hz.Md_Stall_Cnt = md_cnt;
  assign hz.Flush_Cnt    = fl_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed hazard scenarios then randomized traffic,
// checked against a cycle-count reference model of the pipeline sequencing rules.
module tb_hazard_stall_controller;
  import hazard_pkg::*;

  localparam int LAT = 4;

  logic      clk;
  logic      rst;
  hz_state_t state_dbg;

  hazard_stall_controller_if hz_if ();

  hazard_stall_controller #(.MULDIV_LAT(LAT), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (hz_if),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: which EX cycle of a mul/div op we are in (0 = none, start cycle is 1)
  int n_vec = 0;
  int n_err = 0;
  int md_cyc = 0;
  int m_ld = 0, m_md = 0, m_fl = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input int rs, input int rt, input bit uses, input int rt_ex,
                        input bit mem_rd, input bit br, input bit jmp, input bit start);
    hz_if.Rs_IF_ID           = 5'(rs);
    hz_if.Rt_IF_ID           = 5'(rt);
    hz_if.Uses_Rt_IF_ID      = uses;
    hz_if.Rt_ID_EX           = 5'(rt_ex);
    hz_if.Mem_Read_ID_EX     = mem_rd;
    hz_if.Branch_Taken_ID    = br;
    hz_if.Jump_ID            = jmp;
    hz_if.MulDiv_Start_ID_EX = start;
  endtask

  function automatic int sat_inc(input int v, input bit ev);
    return (ev && v < 65535) ? v + 1 : v;
  endfunction

  // One clock: check at negedge against the model, advance the model, re-arm after posedge.
  task automatic step();
    logic [7:0] exp, got;
    bit lu, redir, hazard_free;
    @(negedge clk);
    lu = hz_if.Mem_Read_ID_EX && (hz_if.Rt_ID_EX != 5'd0) &&
         ((hz_if.Rt_ID_EX == hz_if.Rs_IF_ID) ||
          (hz_if.Uses_Rt_IF_ID && (hz_if.Rt_ID_EX == hz_if.Rt_IF_ID)));
    redir = hz_if.Branch_Taken_ID || hz_if.Jump_ID;
    hazard_free = 1'b0;
    // bits: PC, IF_ID_W, ID_EX_W, Flush, ID_EX_Bub, EX_MEM_Bub, Busy, Done
    if (!rst)                                        exp = 8'b0000_0000;
    else if (md_cyc == 0 && hz_if.MulDiv_Start_ID_EX) exp = 8'b0000_0100;
    else if (md_cyc == 0 && lu)                       exp = 8'b0010_1000;
    else if (md_cyc == 0) begin
      exp = {3'b111, redir, 4'b0000};
      hazard_free = 1'b1;
    end
    else if (md_cyc < LAT)                            exp = 8'b0000_0110;
    else                                              exp = {3'b111, redir, 4'b0011};
    got = {hz_if.PC_Write, hz_if.IF_ID_Write, hz_if.ID_EX_Write, hz_if.IF_ID_Flush,
           hz_if.ID_EX_Bubble, hz_if.EX_MEM_Bubble, hz_if.MulDiv_Busy, hz_if.MulDiv_Done};
    check(hazard_free ? "outs_free" : "outs", 32'(got), 32'(exp));
    check("state_mdbusy", 32'(state_dbg == MDBUSY), 32'(rst && md_cyc >= 2));
`ifdef STALL_PERF_EN
    check("ld_cnt", 32'(hz_if.Ld_Stall_Cnt), 32'(m_ld));
    check("md_cnt", 32'(hz_if.Md_Stall_Cnt), 32'(m_md));
    check("fl_cnt", 32'(hz_if.Flush_Cnt), 32'(m_fl));
`endif
    if (!rst) begin
      md_cyc = 0;
      m_ld = 0; m_md = 0; m_fl = 0;
    end else begin
      if (md_cyc == 0)        md_cyc = hz_if.MulDiv_Start_ID_EX ? 2 : 0;
      else if (md_cyc < LAT)  md_cyc = md_cyc + 1;
      else                    md_cyc = 0;
`ifdef STALL_PERF_EN
      if (hz_if.Perf_Clr) begin
        m_ld = 0; m_md = 0; m_fl = 0;
      end else begin
        m_ld = sat_inc(m_ld, exp[3]);
        m_md = sat_inc(m_md, exp[2]);
        m_fl = sat_inc(m_fl, exp[4]);
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
`ifdef STALL_PERF_EN
    hz_if.Perf_Clr = 1'b0;
`endif
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    step();                                 // reset state
    rst = 1'b1;
    step();                                 // idle advance

    set_in(5, 7, 1, 5, 1, 0, 0, 0); step(); // lw $5 / add $6,$5,$7: stall
    set_in(5, 7, 1, 5, 0, 0, 0, 0); step(); // bubble in EX: clear
    set_in(0, 3, 1, 0, 1, 0, 0, 0); step(); // $0 never stalls
    set_in(4, 5, 0, 5, 1, 0, 0, 0); step(); // Rt match but Rt not read
    set_in(4, 5, 1, 5, 1, 0, 0, 0); step(); // Rt match, Rt read: stall

    set_in(0, 0, 0, 0, 0, 0, 0, 1); step(); // mul/div start
    set_in(0, 0, 0, 0, 0, 1, 0, 1); step(); // busy, branch ignored
    set_in(0, 0, 0, 0, 0, 0, 1, 1); step(); // busy, jump ignored
    set_in(0, 0, 0, 0, 0, 1, 0, 1); step(); // done cycle, flush
    set_in(5, 0, 0, 5, 1, 1, 0, 0); step(); // load-use + branch: stall only
    set_in(5, 0, 0, 5, 0, 1, 0, 0); step(); // branch re-evaluated: flush

    set_in(1, 2, 1, 3, 0, 0, 0, 1); step(); // start
    set_in(1, 2, 1, 3, 0, 0, 0, 0); step(); // cnt 3 -> 2
    rst = 1'b0;                    step(); // reset mid-op
    rst = 1'b1;
    set_in(1, 2, 1, 3, 0, 0, 0, 0); step(); // back in RUN
    step();

    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) == 0));
      rst = ($urandom_range(0, 79) != 0);
`ifdef STALL_PERF_EN
      hz_if.Perf_Clr = ($urandom_range(0, 39) == 0);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Generates PC/IF_ID/ID_EX write enables, bubbles and flushes for four cases:
  - load-use hazards, which forwarding cannot resolve;
  - taken branches and jumps resolved in ID;
  - multi-cycle mul/div ops occupying EX;
  - normal advance (no hazard).
- Sits beside the forwarding logic.
- Owns all freeze/flush decisions; the datapath registers only obey its enables.

Parameters:
- MULDIV_LAT, 4: total EX-stage cycles of a mul/div op. Legal range 2..15.
- CNT_W, 4: width of the internal busy counter. Must satisfy 2^CNT_W > MULDIV_LAT.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Rs_IF_ID  in  5  Rs field of the instruction in ID
- Rt_IF_ID  in  5  Rt field of the instruction in ID
- Uses_Rt_IF_ID  in  1  ID instruction reads Rt as a source
- Rt_ID_EX  in  5  destination of the load in EX
- Mem_Read_ID_EX  in  1  EX instruction is a load
- Branch_Taken_ID  in  1  branch in ID resolved taken
- Jump_ID  in  1  jump in ID
- MulDiv_Start_ID_EX  in  1  EX instruction is mul/div
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- ID_EX_Write  out  1  ID/EX register enable
- IF_ID_Flush  out  1  zero the IF/ID register
- ID_EX_Bubble  out  1  zero the control fields entering ID/EX
- EX_MEM_Bubble  out  1  zero the control fields entering EX/MEM
- MulDiv_Busy  out  1  state is MDBUSY
- MulDiv_Done  out  1  final EX cycle of a mul/div; result valid

Behaviour:
- Reset:
  - While rst=0: state=RUN, cnt=0.
  - All outputs forced to 0, including the write enables; no register updates.
- Outputs are Mealy: combinational from state, cnt and inputs.
- Default (no event): writes=1, flush/bubbles=0, Busy=0, Done=0.
- FSM states: RUN, MDBUSY.
- RUN, MulDiv_Start_ID_EX=1:
  - PC_Write=IF_ID_Write=ID_EX_Write=0, EX_MEM_Bubble=1.
  - cnt<=MULDIV_LAT-1, next=MDBUSY.
  - Load-use and flush are suppressed this cycle.
- MDBUSY, cnt>1:
  - Same freeze as the start cycle.
  - cnt<=cnt-1.
  - Branch_Taken_ID and Jump_ID are ignored.
- MDBUSY, cnt==1:
  - Done=1, writes=1, EX_MEM_Bubble=0, next=RUN, cnt<=0.
  - Branch flush is evaluated normally this cycle.
  - MulDiv_Start_ID_EX is not re-sampled in MDBUSY.
- Stall timing: total EX occupancy = MULDIV_LAT cycles, of which MULDIV_LAT-1 are stalled.
- Load-use hazard, evaluated in RUN only:
  - Condition: Mem_Read_ID_EX && Rt_ID_EX!=0 && (Rt_ID_EX==Rs_IF_ID || (Uses_Rt_IF_ID && Rt_ID_EX==Rt_IF_ID)).
  - Response: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, ID_EX_Write=1.
  - Exactly one cycle; the bubble clears Mem_Read, so the hazard does not repeat.
- Flush:
  - IF_ID_Flush = (Branch_Taken_ID || Jump_ID) && no load-use && not frozen.
  - PC_Write stays 1 so the target loads.
- Priority: mul/div freeze > load-use stall > branch flush.
  - A branch coinciding with a load-use hazard is not flushed; it is re-evaluated next cycle with forwarded operands.
- Register $0 never causes a stall.
- Reset asserted mid-MDBUSY: immediate return to RUN, cnt=0. The aborted op is not completed.

Optional Feature:
- Macro: STALL_PERF_EN.
- When defined, add these ports:
  - Perf_Clr  in  1  synchronous clear of all counters; clear wins over increment.
  - Ld_Stall_Cnt  out  16  count of load-use stall cycles.
  - Md_Stall_Cnt  out  16  count of mul/div frozen cycles.
  - Flush_Cnt  out  16  count of IF_ID_Flush cycles.
- Counter behaviour:
  - All counters saturate at 16'hFFFF.
  - All reset to 0 on rst.
  - Each increments on the cycle its event output is asserted.
- When undefined: ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - enum hz_state_t {RUN, MDBUSY};
  - localparam REG_ZERO=5'd0;
  - default MULDIV_LAT.
- One sub-module, muldiv_timer:
  - Loadable down-counter (load, value, dec) with an is_last flag.
  - Instantiated once for cnt.

Test Plan:
- Load-use: lw $5 in EX, add $6,$5,$7 in ID → exactly 1 cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; next cycle all clear.
- Rt_ID_EX=0 with Mem_Read=1, Rs_IF_ID=0 → no stall. Uses_Rt_IF_ID=0 with an Rt match → no stall.
- MulDiv_Start with MULDIV_LAT=4:
  - 3 cycles of freeze with EX_MEM_Bubble=1, MulDiv_Busy high on cycles 2-3;
  - cycle 4: Done=1 and writes=1.
- Branch_Taken_ID during MDBUSY (cnt=3) → no flush; same branch in the Done cycle → IF_ID_Flush=1.
- Load-use plus Branch_Taken_ID in the same cycle → stall only, flush=0; next cycle flush=1.
- rst low while cnt=2 in MDBUSY → all outputs 0 at once; after release, state RUN, writes=1. Under STALL_PERF_EN, the counters read 0.
